ps2_rx_axis: RTL
================

# ps2_rx_axis

PS/2 keyboard receiver that deserializes device-clocked 11-bit frames from the PS2_CLK/PS2_DATA pins and presents validated scan-code bytes as an AXI-stream master. It sits directly upstream of the `if_axis` CPU interface core, in place of the present keyboard stream source, and drives its `s_axis_tvalid_i/s_axis_tdata_i/s_axis_tflag_i` inputs. It handles pin synchronization, clock glitch filtering, frame checking, inter-bit timeout, release-code (F0) tagging and a small output FIFO.

## Interface
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 100000: axis_aclk_i cycles without a falling edge that abort a partial frame (2 ms at 50 MHz).
- FIFO_DEPTH, 4: output FIFO entries; power of 2, at least 2.
- axis_aclk_i  in  1  system clock (50 MHz in the SoC).
- axis_aresetn_i  in  1  reset; asynchronous, active-low.
- ps2_clk_i  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data_i  in  1  raw PS/2 data pin (asynchronous).
- m_axis_tready_i  in  1  downstream ready.
- m_axis_tvalid_o  out  1  FIFO head valid.
- m_axis_tdata_o  out  8  scan-code byte at the FIFO head.
- m_axis_flag_o  out  1  1 = byte is a key release (it was preceded by F0).
- frame_err_o  out  1  one-cycle pulse on a parity, stop or timeout error.
- overflow_o  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- Both pins pass through 2-FF synchronizers.
- Clock filter: `kclk_f` resets to 1. It takes the new level only after FILTER_LEN consecutive equal synchronized samples that differ from its current value.
- A falling edge is `kclk_f` going 1→0, registered. On that cycle the synchronized data bit is sampled.
- Receive FSM states:
  - IDLE: wait for a falling edge. Data 0 (start bit) → SHIFT with bit_cnt=0. Data 1 → stay in IDLE, no error.
  - SHIFT: each edge shifts data into bit 7 of the shift register, shifting right, so data arrives LSB-first. After 8 bits → PARITY.
  - PARITY: each edge stores the parity bit → STOP.
  - STOP: on the edge, the frame is good when the stop bit is 1 and XOR(data, parity) is 1 (odd parity). Good → DONE. Bad → frame_err_o pulse, go to IDLE.
  - DONE (one cycle):
    - Byte 0xF0: set `rel_pend`, push nothing.
    - Any other byte: push {rel_pend, byte}, then clear `rel_pend`.
    - Then go to IDLE.
- Timeout: a counter clears on every falling edge and in IDLE. If it reaches TIMEOUT_CYCLES in SHIFT, PARITY or STOP, the frame is discarded, frame_err_o pulses and the FSM returns to IDLE.
- Errors and timeouts leave `rel_pend` unchanged.
- 0xE0 is not special: it is pushed as ordinary data with flag 0. Sequence E0 F0 75 yields {0,E0} then {1,75}.
- FIFO holds 9-bit entries {flag, data}:
  - tvalid = not empty; tdata/flag = head entry.
  - A pop happens when tvalid & tready.
  - A push while full with no pop in the same cycle drops the byte and pulses overflow_o.
  - A push while full with a pop in the same cycle is accepted.
  - Push while empty: the entry becomes visible on the next cycle.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH. Full/empty are distinguished by the MSB.

## Timing
- Reset values:
  - Outputs: tvalid=0, tdata=0x00, flag=0, frame_err_o=0, overflow_o=0.
  - Internal: FSM=IDLE, `rel_pend`=0, FIFO empty, `kclk_f`=1, synchronizers=1.
- Edge detection latency: 2 (sync) + FILTER_LEN + 1 cycles after the pin's falling edge.
- The stop-bit edge registers DONE on the next cycle. The FIFO write occurs at the end of DONE, and tvalid=1 on the following cycle.
- tdata and flag stay stable while tvalid=1 and tready=0 (AXI-stream rule). tvalid never drops without a handshake.
- Asserting reset mid-frame or with the FIFO non-empty clears everything immediately. The first frame after reset must begin with a new start bit.
- Pulses on the PS/2 clock shorter than FILTER_LEN cycles produce no edge.

## Test plan
- Reset, then send frame 0x1C (start 0, data LSB-first, parity 0, stop 1) at a 12.5 kHz PS/2 clock with tready=1 → exactly one beat with tdata=0x1C, flag=0, and no error pulse.
- Send F0 then 1C → one beat only, with tdata=0x1C and flag=1. Next send 1C → tdata=0x1C, flag=0.
- Send 0x1C with parity bit 1, then send a frame with stop bit 0 → no beats and two frame_err_o pulses. A following good 0x32 frame → beat 0x32.
- Hold tready=0 and send 5 good bytes 01..05 with FIFO_DEPTH=4 → one overflow_o pulse on byte 05. Then raise tready → beats 01,02,03,04 in order, then tvalid=0.
- Stop the PS/2 clock after 4 data bits, wait TIMEOUT_CYCLES+10 cycles → frame_err_o pulse and no beat. A subsequent full 0x5A frame → beat 0x5A.
- Inject 3-cycle glitches low on ps2_clk_i while idle → no edge and no state change. Assert reset mid-frame for 1 cycle → all outputs 0, and the partial frame produces no beat.

Source files
------------

// File: rtl/ps2_rx_axis.sv
// PS/2 keyboard receiver: synchronizes and filters the device clock, deserializes
// 11-bit odd-parity frames, tags bytes that follow F0 as releases, and queues them on AXI-stream.
module ps2_rx_axis #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       axis_aclk_i,
  input  logic       axis_aresetn_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       m_axis_tready_i,
  output logic       m_axis_tvalid_o,
  output logic [7:0] m_axis_tdata_o,
  output logic       m_axis_flag_o,
  output logic       frame_err_o,
  output logic       overflow_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, STOP, DONE} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_kclk_f, r_kclk_q, r_fall;
  logic [FW-1:0] r_filt_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_rel_pend;
  logic          r_frame_err, r_overflow;
  state_t        r_state, w_state_nx;
  logic          w_err, w_push, w_timeout;
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic          w_empty, w_full, w_pop, w_wr, w_drop;
  logic [8:0]    w_head;

  // Synchronizers, then a level filter: the clock only moves after FILTER_LEN agreeing samples
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_kclk_f   <= 1'b1;
      r_kclk_q   <= 1'b1;
      r_fall     <= 1'b0;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= ps2_clk_i;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_i;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 == r_kclk_f) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_kclk_f   <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
      r_kclk_q <= r_kclk_f;
      r_fall   <= r_kclk_q & ~r_kclk_f;
    end
  end

  assign w_timeout = (r_to_cnt >= TW'(TIMEOUT_CYCLES));

  always_comb begin
    w_state_nx = r_state;
    w_err      = 1'b0;
    w_push     = 1'b0;
    unique case (r_state)
      IDLE:   if (r_fall && !r_dat_s2) w_state_nx = SHIFT;
      SHIFT: begin
        if (w_timeout) begin
          w_state_nx = IDLE;
          w_err      = 1'b1;
        end else if (r_fall && r_bit_cnt == 3'd7) begin
          w_state_nx = PARITY;
        end
      end
      PARITY: begin
        if (w_timeout) begin
          w_state_nx = IDLE;
          w_err      = 1'b1;
        end else if (r_fall) begin
          w_state_nx = STOP;
        end
      end
      STOP: begin
        if (w_timeout) begin
          w_state_nx = IDLE;
          w_err      = 1'b1;
        end else if (r_fall) begin
          if (r_dat_s2 && (^{r_shift, r_par})) begin
            w_state_nx = DONE;
          end else begin
            w_state_nx = IDLE;
            w_err      = 1'b1;
          end
        end
      end
      DONE: begin
        w_push     = (r_shift != 8'hF0);
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_to_cnt    <= '0;
      r_rel_pend  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_frame_err <= w_err;
      if (r_state == IDLE || r_fall) r_to_cnt <= '0;
      else                           r_to_cnt <= r_to_cnt + 1'b1;
      if (r_state == IDLE)                r_bit_cnt <= '0;
      else if (r_state == SHIFT && r_fall) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (r_state == DONE) r_rel_pend <= (r_shift == 8'hF0);
    end
  end

  // Byte assembly: LSB arrives first, so each new bit enters at the top
  always_ff @(posedge axis_aclk_i) begin
    if (r_state == SHIFT && r_fall && !w_timeout)  r_shift <= {r_dat_s2, r_shift[7:1]};
    if (r_state == PARITY && r_fall && !w_timeout) r_par   <= r_dat_s2;
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {r_rel_pend, r_shift};
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~w_empty & m_axis_tready_i;
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_head  = w_empty ? 9'h000 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_overflow <= w_drop;
    end
  end

  assign m_axis_tvalid_o = ~w_empty;
  assign m_axis_tdata_o  = w_head[7:0];
  assign m_axis_flag_o   = w_head[8];
  assign frame_err_o     = r_frame_err;
  assign overflow_o      = r_overflow;

endmodule
